tap_loader: RTL and testbench
=============================

TAP_LOADER -- requirements
Module: tap_loader

Interface
REQ-001 SHALL have parameter TW, default 16: coefficient width, matching the tap chain's tap width.
REQ-002 SHALL have parameter NTAPS, default 128, legal values 2 or more: number of taps in the downstream chain.
REQ-003 SHALL have parameter LGNTAPS, default $clog2(NTAPS+1): width of the count output.
REQ-004 SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port i_reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port i_start, input, 1 bit: request to load NTAPS coefficients from the stream.
REQ-007 SHALL have port i_clear, input, 1 bit: request to write NTAPS zero coefficients.
REQ-008 SHALL have port i_abort, input, 1 bit: cancel the current operation.
REQ-009 SHALL have port i_valid, input, 1 bit: coefficient stream valid.
REQ-010 SHALL have port i_coeff, input, TW bits: coefficient stream data.
REQ-011 SHALL have port o_ready, output, 1 bit: coefficient stream ready.
REQ-012 SHALL have port o_tap_wr, output, 1 bit: shift strobe into the head of the tap chain.
REQ-013 SHALL have port o_tap, output, TW bits: tap value presented with o_tap_wr.
REQ-014 SHALL have port o_busy, output, 1 bit: high while loading; the parent uses it to gate the filter's i_ce.
REQ-015 SHALL have port o_done, output, 1 bit: one-cycle pulse when a complete load or clear finishes.
REQ-016 SHALL have port o_count, output, LGNTAPS bits: number of taps written in the current or last operation.

Function
REQ-017 SHALL implement the states IDLE, LOAD, CLEAR and FINISH.
REQ-018 SHALL, in IDLE, move to CLEAR when i_clear is high, else to LOAD when i_start is high, and zero o_count on either transition (clear has priority when both are high).
REQ-019 SHALL ignore i_start and i_clear outside IDLE.
REQ-020 SHALL drive o_ready high only while in LOAD; a word is accepted when i_valid and o_ready are both high.
REQ-021 SHALL, for a word accepted in cycle n, drive o_tap_wr=1 and o_tap=i_coeff in cycle n+1 and increment o_count at the same edge.
REQ-022 SHALL drive o_tap_wr low in every cycle that does not follow an acceptance (in LOAD) or a clear step; o_tap SHALL hold its last value when o_tap_wr is low.
REQ-023 SHALL wait indefinitely in LOAD for i_valid, with no timeout.
REQ-024 SHALL, in CLEAR, issue o_tap_wr=1 with o_tap=0 in each of NTAPS consecutive cycles, the first one cycle after entry, with no handshake.
REQ-025 SHALL move from LOAD or CLEAR to FINISH at the edge that issues the NTAPS-th write.
REQ-026 SHALL, in FINISH, pulse o_done for exactly one cycle, the cycle after the last o_tap_wr, then return to IDLE.
REQ-027 SHALL keep o_busy high in LOAD, CLEAR and FINISH, and low in IDLE; o_busy falls in the cycle after o_done.
REQ-028 SHALL write the first coefficient first, so that it ends in the deepest tap after NTAPS shifts.
REQ-029 SHALL, on i_abort in LOAD or CLEAR, return to IDLE at the next edge with no o_done and no further o_tap_wr; the write of a word accepted in the abort cycle still completes, and o_count retains the writes made.
REQ-030 SHALL ignore i_abort in IDLE and FINISH.
REQ-031 SHALL not let o_count exceed NTAPS.

Reset
REQ-032 SHALL, while i_reset is high, immediately (without waiting for a clock edge) force state=IDLE, o_ready=0, o_tap_wr=0, o_tap=0, o_busy=0, o_done=0 and o_count=0.
REQ-033 SHALL, on reset mid-operation, discard the operation with no o_done.

Verification (NTAPS=4, TW=16)
REQ-034 SHALL cover a streamed load: i_start, then i_valid held high with words 1, 2, 3, 4 -> o_tap_wr high 4 consecutive cycles with o_tap 1, 2, 3, 4, then o_done pulse, then o_busy low; o_count=4.
REQ-035 SHALL cover back-pressure: gaps of 2 idle cycles between words -> o_tap_wr high only in the cycle after each acceptance, and identical end values.
REQ-036 SHALL cover a clear: i_clear together with i_start -> CLEAR taken, 4 zero writes on consecutive cycles, o_done, o_count=4.
REQ-037 SHALL cover an abort: i_abort after 2 accepted words -> no o_done, o_count=2, o_busy low; a following i_start loads normally.
REQ-038 SHALL cover asynchronous reset asserted between clock edges during LOAD -> all outputs zero immediately; i_start during FINISH is ignored.

Source files
------------

// File: rtl/tap_loader.sv
// rtl/tap_loader.sv - streams or zero-fills NTAPS coefficients into the head of a tap chain
module tap_loader #(
  parameter int TW      = 16,
  parameter int NTAPS   = 128,
  parameter int LGNTAPS = $clog2(NTAPS+1)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_clear,
  input  logic               i_abort,
  input  logic               i_valid,
  input  logic [TW-1:0]      i_coeff,
  output logic               o_ready,
  output logic               o_tap_wr,
  output logic [TW-1:0]      o_tap,
  output logic               o_busy,
  output logic               o_done,
  output logic [LGNTAPS-1:0] o_count
);

  typedef enum logic [1:0] {IDLE, LOAD, CLEAR, FINISH} state_t;

  localparam logic [LGNTAPS-1:0] LAST_CNT = LGNTAPS'(NTAPS-1);

  state_t state, state_nxt;
  logic   accept;
  logic   clr_step;
  logic   cnt_zero;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    clr_step  = 1'b0;
    cnt_zero  = 1'b0;
    case (state)
      IDLE: begin
        if (i_clear) begin
          state_nxt = CLEAR;
          cnt_zero  = 1'b1;
        end else if (i_start) begin
          state_nxt = LOAD;
          cnt_zero  = 1'b1;
        end
      end
      LOAD: begin
        // A word offered in the abort cycle is still taken and written.
        accept = i_valid;
        if (i_abort)
          state_nxt = IDLE;
        else if (i_valid && o_count == LAST_CNT)
          state_nxt = FINISH;
      end
      CLEAR: begin
        if (i_abort)
          state_nxt = IDLE;
        else begin
          clr_step = 1'b1;
          if (o_count == LAST_CNT)
            state_nxt = FINISH;
        end
      end
      FINISH: begin
        // Two cycles: the trailing write, then the done pulse.
        if (o_done)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign o_ready = (state == LOAD);
  assign o_busy  = (state != IDLE);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_tap_wr <= 1'b0;
      o_tap    <= '0;
      o_done   <= 1'b0;
      o_count  <= '0;
    end else begin
      o_tap_wr <= accept | clr_step;
      if (accept)
        o_tap <= i_coeff;
      else if (clr_step)
        o_tap <= '0;
      if (cnt_zero)
        o_count <= '0;
      else if (accept || clr_step)
        o_count <= o_count + LGNTAPS'(1);
      o_done <= (state == FINISH) && !o_done;
    end
  end

endmodule

// File: tb/tb_tap_loader.sv
// tb/tb_tap_loader.sv - randomized directed bench for tap_loader against a transaction-level model
module tb_tap_loader;
  localparam int TW      = 16;
  localparam int NTAPS   = 4;
  localparam int LGNTAPS = $clog2(NTAPS+1);

  logic               i_clk;
  logic               i_reset;
  logic               i_start;
  logic               i_clear;
  logic               i_abort;
  logic               i_valid;
  logic [TW-1:0]      i_coeff;
  logic               o_ready;
  logic               o_tap_wr;
  logic [TW-1:0]      o_tap;
  logic               o_busy;
  logic               o_done;
  logic [LGNTAPS-1:0] o_count;

  tap_loader #(.TW(TW), .NTAPS(NTAPS), .LGNTAPS(LGNTAPS)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_clear(i_clear),
    .i_abort(i_abort), .i_valid(i_valid), .i_coeff(i_coeff), .o_ready(o_ready),
    .o_tap_wr(o_tap_wr), .o_tap(o_tap), .o_busy(o_busy), .o_done(o_done),
    .o_count(o_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  logic [TW-1:0] wr_vals[$];
  int            wr_cycs[$];
  int            done_cycs[$];
  logic          busy_hist[0:8191];

  always @(negedge i_clk) begin
    if (!i_reset) begin
      if (o_tap_wr) begin
        wr_vals.push_back(o_tap);
        wr_cycs.push_back(cyc);
      end
      if (o_done) done_cycs.push_back(cyc);
      if (cyc < 8192) busy_hist[cyc] = o_busy;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clr_mon();
    wr_vals.delete();
    wr_cycs.delete();
    done_cycs.delete();
  endtask

  // Model: every accepted word appears once, in order, one cycle after acceptance;
  // done follows the last write by one cycle only when NTAPS words went in unaborted.
  task automatic check_op(input string tag, input logic [TW-1:0] exp_vals[$],
                          input int exp_cycs[$], input bit exp_done);
    check({tag, "_wr_n"}, wr_vals.size(), exp_vals.size());
    for (int i = 0; i < exp_vals.size() && i < wr_vals.size(); i++) begin
      check({tag, "_tap"}, wr_vals[i], exp_vals[i]);
      check({tag, "_wr_cyc"}, wr_cycs[i], exp_cycs[i]);
    end
    check({tag, "_done_n"}, done_cycs.size(), exp_done ? 1 : 0);
    if (exp_done && done_cycs.size() > 0 && wr_cycs.size() > 0) begin
      check({tag, "_done_cyc"}, done_cycs[0], wr_cycs[wr_cycs.size()-1] + 1);
      check({tag, "_busy_at_done"}, busy_hist[done_cycs[0]], 1);
      check({tag, "_busy_after"}, busy_hist[done_cycs[0]+1], 0);
    end
    check({tag, "_count"}, o_count, (exp_vals.size() > NTAPS) ? NTAPS : exp_vals.size());
    check({tag, "_busy_end"}, o_busy, 0);
    check({tag, "_ready_end"}, o_ready, 0);
  endtask

  task automatic run_load(input string tag, input int min_gap, input int max_gap,
                          input int abort_after, input bit abort_with_word,
                          input bit fixed, input bit start_in_finish);
    logic [TW-1:0] exp_vals[$];
    int            exp_cycs[$];
    logic [TW-1:0] w;
    bit            aborted;
    aborted = 0;
    clr_mon();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int k = 0; k < NTAPS && !aborted; k++) begin
      if (k == abort_after) begin
        i_abort = 1'b1;
        if (abort_with_word) begin
          w = TW'($urandom);
          i_valid = 1'b1;
          i_coeff = w;
          exp_vals.push_back(w);
          exp_cycs.push_back(cyc + 1);
        end
        tick();
        i_abort = 1'b0;
        i_valid = 1'b0;
        aborted = 1;
      end else begin
        repeat ($urandom_range(max_gap, min_gap)) tick();
        w = fixed ? TW'(k + 1) : TW'($urandom);
        i_valid = 1'b1;
        i_coeff = w;
        exp_vals.push_back(w);
        exp_cycs.push_back(cyc + 1);
        tick();
        i_valid = 1'b0;
      end
    end
    if (start_in_finish) begin
      i_start = 1'b1;
      tick();
      tick();
      i_start = 1'b0;
    end
    repeat (6) tick();
    check_op(tag, exp_vals, exp_cycs, !aborted);
  endtask

  task automatic run_clear();
    logic [TW-1:0] exp_vals[$];
    int            exp_cycs[$];
    int            c0;
    clr_mon();
    c0 = cyc;
    i_clear = 1'b1;
    i_start = 1'b1;
    tick();
    i_clear = 1'b0;
    i_start = 1'b0;
    for (int i = 0; i < NTAPS; i++) begin
      exp_vals.push_back('0);
      exp_cycs.push_back(c0 + 2 + i);
    end
    repeat (NTAPS + 6) tick();
    check_op("clear", exp_vals, exp_cycs, 1'b1);
  endtask

  initial begin
    i_reset = 1'b1;
    i_start = 1'b0;
    i_clear = 1'b0;
    i_abort = 1'b0;
    i_valid = 1'b0;
    i_coeff = '0;
    #2;
    check("rst_ready", o_ready, 0);
    check("rst_tap_wr", o_tap_wr, 0);
    check("rst_tap", o_tap, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_count", o_count, 0);
    tick();
    tick();
    i_reset = 1'b0;
    tick();

    run_load("stream", 0, 0, -1, 1'b0, 1'b1, 1'b0);
    run_load("gap2", 2, 2, -1, 1'b0, 1'b0, 1'b0);
    run_clear();
    run_load("abort2", 0, 1, 2, 1'b0, 1'b0, 1'b0);
    run_load("after_abort", 0, 0, -1, 1'b0, 1'b0, 1'b0);
    run_load("abort_word", 0, 1, 1, 1'b1, 1'b0, 1'b0);
    run_load("start_in_fin", 0, 1, -1, 1'b0, 1'b0, 1'b1);
    for (int r = 0; r < 4; r++)
      run_load("rand", 0, 3, -1, 1'b0, 1'b0, 1'b0);

    clr_mon();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    i_valid = 1'b1;
    i_coeff = TW'($urandom) | TW'(1);
    tick();
    i_valid = 1'b0;
    #2;
    i_reset = 1'b1;
    #1;
    check("arst_ready", o_ready, 0);
    check("arst_tap_wr", o_tap_wr, 0);
    check("arst_tap", o_tap, 0);
    check("arst_busy", o_busy, 0);
    check("arst_done", o_done, 0);
    check("arst_count", o_count, 0);
    tick();
    i_reset = 1'b0;
    repeat (8) tick();
    check("arst_no_done", done_cycs.size(), 0);
    check("arst_idle", o_busy, 0);
    run_load("post_rst", 0, 2, -1, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
